// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - ID/EX hazard signal bundle between the pipeline and the stall controller
//
// Signals (driven by the pipeline, i.e. the master side):
//   id_rs, id_rt       source registers of the instruction in ID
//   id_uses_rs/rt      ID instruction actually reads rs / rt
//   id_reads_hilo      ID instruction is mfhi/mflo
//   id_mdu_op          ID instruction is mult/multu/div/divu
//   ex_rt              destination register of the load in EX
//   ex_mem_read        EX instruction is a load
//   ex_mdu_start       EX instruction starts the MDU (one-cycle pulse)
//   ex_branch_taken    branch/jump resolved taken in EX
// Signals (driven by the controller, i.e. the slave side):
//   pc_write, ifid_write, haz_mux_con, ifid_flush, mdu_busy
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reads_hilo;
    logic              id_mdu_op;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mem_read;
    logic              ex_mdu_start;
    logic              ex_branch_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              haz_mux_con;
    logic              ifid_flush;
    logic              mdu_busy;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, id_mdu_op,
               ex_rt, ex_mem_read, ex_mdu_start, ex_branch_taken,
        input  pc_write, ifid_write, haz_mux_con, ifid_flush, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, id_mdu_op,
               ex_rt, ex_mem_read, ex_mdu_start, ex_branch_taken,
        output pc_write, ifid_write, haz_mux_con, ifid_flush, mdu_busy
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID/EX hazard and stall controller for the 5-stage MIPS pipeline
//
// Detects load-use hazards (LOAD_LAT bubbles each), HI/LO and structural
// hazards against the multi-cycle MDU (MDU_LAT busy cycles after a start),
// and flushes IF/ID on a taken branch. Outputs are combinational from the
// current hazard inputs and the registered state.
//
// Parameters:
//   REG_AW    register-address width
//   LOAD_LAT  bubbles inserted per load-use hazard (>=1)
//   MDU_LAT   MDU busy cycles after a start (>=1)
// Ports:
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset; forces all outputs to 0
//   hz           hazard_stall_ctrl_if.slave bundle (ID/EX inputs, control outputs)
//   stall_count  32-bit saturating count of edges with pc_write==0
//                (present only when HAZ_STALL_CNT_EN is defined)
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave hz
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    localparam int LDW = ($clog2(LOAD_LAT + 1) < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam int MDW = ($clog2(MDU_LAT + 1) < 1) ? 1 : $clog2(MDU_LAT + 1);

    // The detection cycle is itself the first bubble, so the FSM only has
    // to cover the remaining LOAD_LAT-1 cycles.
    localparam logic [LDW-1:0] LD_INIT  = LDW'(LOAD_LAT - 1);
    localparam logic [MDW-1:0] MDU_INIT = MDW'(MDU_LAT);
    localparam bit             LD_MULTI = (LOAD_LAT > 1);

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LDW-1:0]   ld_cnt_q;
    logic [LDW-1:0]   ld_cnt_d;
    logic [MDW-1:0]   mdu_cnt_q;
    logic [MDW-1:0]   mdu_cnt_d;

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] ex_rt;

    logic load_hz;
    logic mdu_busy_w;
    logic mdu_hz;
    logic stall;

    logic pc_write_w;
    logic ifid_write_w;
    logic haz_mux_con_w;
    logic ifid_flush_w;

    assign id_rs = hz.id_rs;
    assign id_rt = hz.id_rt;
    assign ex_rt = hz.ex_rt;

    // r0 is hardwired to zero, so a load "into" r0 never creates a hazard;
    // the uses_* qualifiers stop immediates/shamt fields from matching.
    assign load_hz = hz.ex_mem_read && (ex_rt != '0) &&
                     ((hz.id_uses_rs && (id_rs == ex_rt)) ||
                      (hz.id_uses_rt && (id_rt == ex_rt)));

    assign mdu_busy_w = (mdu_cnt_q != '0);
    assign mdu_hz     = mdu_busy_w && (hz.id_reads_hilo || hz.id_mdu_op);

    // A load hazard is only sampled in RUN; once in LD_STALL the FSM alone
    // decides the length, so a lingering ex_mem_read cannot extend it.
    assign stall = ((state_q == RUN) && load_hz) || (state_q == LD_STALL) || mdu_hz;

    // ------------------------------------------------------------------
    // Load-use FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        if (hz.ex_branch_taken) begin
            // The flushed ID instruction no longer needs its stall.
            state_d  = RUN;
            ld_cnt_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load_hz && LD_MULTI) begin
                        state_d  = LD_STALL;
                        ld_cnt_d = LD_INIT;
                    end
                end
                LD_STALL: begin
                    if (ld_cnt_q <= LDW'(1)) begin
                        state_d  = RUN;
                        ld_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q - LDW'(1);
                    end
                end
                default: begin
                    state_d  = RUN;
                    ld_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MDU busy counter: a new start always reloads the full latency, and
    // branches do not cancel an operation already issued to the MDU.
    // ------------------------------------------------------------------
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (hz.ex_mdu_start) begin
            mdu_cnt_d = MDU_INIT;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_q <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs, branch flush has priority over stalls
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_w    = 1'b0;
        ifid_write_w  = 1'b0;
        haz_mux_con_w = 1'b0;
        ifid_flush_w  = 1'b0;
        if (!rst_n) begin
            pc_write_w    = 1'b0;
        end else if (hz.ex_branch_taken) begin
            pc_write_w    = 1'b1;
            ifid_write_w  = 1'b1;
            ifid_flush_w  = 1'b1;
            haz_mux_con_w = 1'b0;
        end else if (stall) begin
            pc_write_w    = 1'b0;
        end else begin
            pc_write_w    = 1'b1;
            ifid_write_w  = 1'b1;
            haz_mux_con_w = 1'b1;
        end
    end

    assign hz.pc_write    = pc_write_w;
    assign hz.ifid_write  = ifid_write_w;
    assign hz.haz_mux_con = haz_mux_con_w;
    assign hz.ifid_flush  = ifid_flush_w;
    assign hz.mdu_busy    = rst_n && mdu_busy_w;

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!pc_write_w && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - randomized self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int AW      = 5;
    localparam int MDU_LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] id_rs, id_rt, ex_rt;
    logic id_uses_rs, id_uses_rt, id_reads_hilo, id_mdu_op;
    logic ex_mem_read, ex_mdu_start, ex_branch_taken;

    hazard_stall_ctrl_if #(.REG_AW(AW)) bus3 ();
    hazard_stall_ctrl_if #(.REG_AW(AW)) bus1 ();

    assign bus3.id_rs = id_rs;             assign bus1.id_rs = id_rs;
    assign bus3.id_rt = id_rt;             assign bus1.id_rt = id_rt;
    assign bus3.ex_rt = ex_rt;             assign bus1.ex_rt = ex_rt;
    assign bus3.id_uses_rs = id_uses_rs;   assign bus1.id_uses_rs = id_uses_rs;
    assign bus3.id_uses_rt = id_uses_rt;   assign bus1.id_uses_rt = id_uses_rt;
    assign bus3.id_reads_hilo = id_reads_hilo; assign bus1.id_reads_hilo = id_reads_hilo;
    assign bus3.id_mdu_op = id_mdu_op;     assign bus1.id_mdu_op = id_mdu_op;
    assign bus3.ex_mem_read = ex_mem_read; assign bus1.ex_mem_read = ex_mem_read;
    assign bus3.ex_mdu_start = ex_mdu_start; assign bus1.ex_mdu_start = ex_mdu_start;
    assign bus3.ex_branch_taken = ex_branch_taken; assign bus1.ex_branch_taken = ex_branch_taken;

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] sc3, sc1;
`endif

    hazard_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .MDU_LAT(MDU_LAT)) dut3 (
        .clk(clk), .rst_n(rst_n), .hz(bus3)
`ifdef HAZ_STALL_CNT_EN
        , .stall_count(sc3)
`endif
    );

    hazard_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .MDU_LAT(MDU_LAT)) dut1 (
        .clk(clk), .rst_n(rst_n), .hz(bus1)
`ifdef HAZ_STALL_CNT_EN
        , .stall_count(sc1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Reference model: hazards expressed as windows of cycle numbers.
    // A load stall occupies cycles [T, T+LAT-1]; an MDU start at T makes the
    // unit busy through T+MDU_LAT.
    longint cyc = 0;
    longint ld_until[2];
    longint mdu_until;
    int     lat[2] = '{3, 1};
    longint sc_exp[2];

    logic o_pc[2], o_ifw[2], o_hmc[2], o_fl[2], o_busy[2];
    int   cnt_st[2];
    int   cnt_busy;

    function automatic bit model_load_hz();
        return ex_mem_read && (ex_rt != 0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    // Entered just after a negedge with inputs already set; returns at the
    // following negedge after the model has absorbed the rising edge.
    task automatic step();
        bit lhz, busy, stl;
        bit e_pc[2], e_ifw[2], e_hmc[2], e_fl[2];
        #1;
        lhz  = model_load_hz();
        busy = (cyc <= mdu_until);
        o_pc[0] = bus3.pc_write;   o_pc[1] = bus1.pc_write;
        o_ifw[0] = bus3.ifid_write; o_ifw[1] = bus1.ifid_write;
        o_hmc[0] = bus3.haz_mux_con; o_hmc[1] = bus1.haz_mux_con;
        o_fl[0] = bus3.ifid_flush; o_fl[1] = bus1.ifid_flush;
        o_busy[0] = bus3.mdu_busy; o_busy[1] = bus1.mdu_busy;
        for (int k = 0; k < 2; k++) begin
            stl = (lhz && cyc > ld_until[k]) || (cyc <= ld_until[k]) ||
                  (busy && (id_reads_hilo || id_mdu_op));
            if (!rst_n) begin
                e_pc[k] = 0; e_ifw[k] = 0; e_hmc[k] = 0; e_fl[k] = 0;
            end else if (ex_branch_taken) begin
                e_pc[k] = 1; e_ifw[k] = 1; e_hmc[k] = 0; e_fl[k] = 1;
            end else if (stl) begin
                e_pc[k] = 0; e_ifw[k] = 0; e_hmc[k] = 0; e_fl[k] = 0;
            end else begin
                e_pc[k] = 1; e_ifw[k] = 1; e_hmc[k] = 1; e_fl[k] = 0;
            end
            check($sformatf("pc_write[L%0d]", lat[k]), 32'(o_pc[k]), 32'(e_pc[k]));
            check($sformatf("ifid_write[L%0d]", lat[k]), 32'(o_ifw[k]), 32'(e_ifw[k]));
            check($sformatf("haz_mux_con[L%0d]", lat[k]), 32'(o_hmc[k]), 32'(e_hmc[k]));
            check($sformatf("ifid_flush[L%0d]", lat[k]), 32'(o_fl[k]), 32'(e_fl[k]));
            check($sformatf("mdu_busy[L%0d]", lat[k]), 32'(o_busy[k]), 32'(rst_n && busy));
            if (!o_pc[k]) cnt_st[k]++;
        end
        if (o_busy[0]) cnt_busy++;
`ifdef HAZ_STALL_CNT_EN
        check("stall_count[L3]", sc3, rst_n ? 32'(sc_exp[0]) : 32'd0);
        check("stall_count[L1]", sc1, rst_n ? 32'(sc_exp[1]) : 32'd0);
`endif
        @(posedge clk);
        if (!rst_n) begin
            ld_until[0] = cyc; ld_until[1] = cyc; mdu_until = cyc;
            sc_exp[0] = 0; sc_exp[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!e_pc[k] && sc_exp[k] < 64'hFFFF_FFFF) sc_exp[k]++;
                if (ex_branch_taken) ld_until[k] = cyc;
                else if (cyc > ld_until[k] && lhz) ld_until[k] = cyc + lat[k] - 1;
            end
            if (ex_mdu_start) mdu_until = cyc + MDU_LAT;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_mdu_op = 0;
        ex_mem_read = 0; ex_mdu_start = 0; ex_branch_taken = 0;
    endtask

    task automatic clr_cnt();
        cnt_st[0] = 0; cnt_st[1] = 0; cnt_busy = 0;
    endtask

    task automatic set_load_hz();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    endtask

    initial begin
        ld_until[0] = -1; ld_until[1] = -1; mdu_until = -1;
        sc_exp[0] = 0; sc_exp[1] = 0;
        clr_cnt();
        idle();
        rst_n = 0;
        @(negedge clk);
        step();
        check("reset_pc_write", 32'(o_pc[0]), 32'd0);
        rst_n = 1;
        step();
        check("idle_pc_write", 32'(o_pc[0]), 32'd1);

        // Load-use hazard, load leaves EX after one cycle
        set_load_hz();
        clr_cnt();
        step();
        ex_mem_read = 0;
        repeat (4) step();
        check("ld_len_L3", cnt_st[0], 3);
        check("ld_len_L1", cnt_st[1], 1);

        // r0 destination and unused rs never stall
        set_load_hz(); ex_rt = 0; id_rs = 0;
        clr_cnt();
        repeat (3) step();
        check("ld_r0_nostall", cnt_st[0], 0);
        set_load_hz(); id_uses_rs = 0;
        clr_cnt();
        repeat (3) step();
        check("ld_unused_nostall", cnt_st[0], 0);
        idle();
        step();

        // MDU start then mfhi in ID
        ex_mdu_start = 1;
        step();
        ex_mdu_start = 0; id_reads_hilo = 1;
        clr_cnt();
        repeat (MDU_LAT) step();
        check("mdu_busy_len", cnt_busy, MDU_LAT);
        check("mdu_stall_len", cnt_st[0], MDU_LAT);
        step();
        check("mdu_release_pc", 32'(o_pc[0]), 32'd1);
        check("mdu_release_busy", 32'(o_busy[0]), 32'd0);

        // Restart two cycles after the first start extends busy
        ex_mdu_start = 1; id_reads_hilo = 0;
        step();
        ex_mdu_start = 0; id_reads_hilo = 1;
        clr_cnt();
        step();
        ex_mdu_start = 1;
        step();
        ex_mdu_start = 0;
        repeat (6) step();
        check("mdu_restart_busy", cnt_busy, MDU_LAT + 2);
        idle();
        step();

        // Taken branch in the second load stall cycle
        set_load_hz();
        step();
        ex_mem_read = 0; ex_branch_taken = 1;
        step();
        check("br_flush", 32'(o_fl[0]), 32'd1);
        check("br_pc_write", 32'(o_pc[0]), 32'd1);
        check("br_haz_mux", 32'(o_hmc[0]), 32'd0);
        ex_branch_taken = 0;
        step();
        check("br_after_run", 32'(o_pc[0]), 32'd1);
        idle();

        // Reset in the middle of a load stall and an MDU count
        set_load_hz(); ex_mdu_start = 1;
        step();
        ex_mem_read = 0; ex_mdu_start = 0;
        step();
        rst_n = 0;
        step();
        check("rst_mid_pc", 32'(o_pc[0]), 32'd0);
        check("rst_mid_busy", 32'(o_busy[0]), 32'd0);
        rst_n = 1; idle();
        step();
        check("rst_after_pc", 32'(o_pc[0]), 32'd1);
        check("rst_after_busy", 32'(o_busy[0]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_rs = AW'($urandom_range(0, 3));
            id_rt = AW'($urandom_range(0, 3));
            ex_rt = AW'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_reads_hilo = ($urandom_range(0, 3) == 0);
            id_mdu_op = ($urandom_range(0, 3) == 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_mdu_start = ($urandom_range(0, 9) == 0);
            ex_branch_taken = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised pipeline hazard/stall controller for the 5-stage MIPS core, sitting between ID and EX. It generates PC/IF-ID write enables, the ID/EX bubble-mux select and an IF/ID flush. It covers load-use hazards for memories with multi-cycle load latency, structural and HI/LO hazards against a multi-cycle multiply/divide unit, and taken-branch flushes. Operand-use qualifiers and an r0 filter suppress false stalls.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LOAD_LAT, 1, bubbles inserted per load-use hazard (>=1)
- MDU_LAT, 4, MDU busy cycles after a start (>=1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_AW  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_mdu_op  in  1  ID instruction is mult/multu/div/divu
- ex_rt  in  REG_AW  destination of the load in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_mdu_start  in  1  EX instruction starts the MDU (one-cycle pulse)
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write  out  1  1 = PC updates
- ifid_write  out  1  1 = IF/ID updates
- haz_mux_con  out  1  1 = pass control to ID/EX, 0 = bubble
- ifid_flush  out  1  1 = clear IF/ID to nop
- mdu_busy  out  1  MDU counter nonzero

## Operation
- Interface decision: one clock; reset is asynchronous and active-low.
- State: FSM {RUN, LD_STALL}; ld_cnt (clog2(LOAD_LAT+1) bits); mdu_cnt (clog2(MDU_LAT+1) bits).
- load_hz = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- mdu_hz = mdu_busy & (id_reads_hilo | id_mdu_op).
- stall = load_hz (in RUN) | state==LD_STALL | mdu_hz.
- Priority, highest first:
  - ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, haz_mux_con=0; FSM forced to RUN, ld_cnt=0.
  - stall: pc_write=0, ifid_write=0, haz_mux_con=0, ifid_flush=0.
  - otherwise: pc_write=1, ifid_write=1, haz_mux_con=1, ifid_flush=0.
- FSM: RUN with load_hz and LOAD_LAT>1 goes to LD_STALL, ld_cnt=LOAD_LAT-1. LD_STALL decrements ld_cnt; when ld_cnt==1 it returns to RUN next edge. With LOAD_LAT==1, stays in RUN.
- mdu_cnt: ex_mdu_start loads MDU_LAT, overriding any current count. Otherwise it decrements while nonzero, saturating at 0. ex_branch_taken does not affect it.
- mdu_busy = (mdu_cnt != 0).

## Timing
- Outputs are combinational from inputs and registered state; the stall decision is made in the same cycle the hazard is present.
- Load-use: exactly LOAD_LAT consecutive stall cycles, starting in the detection cycle T.
- MDU: a start in cycle T gives mdu_busy=1 in cycles T+1..T+MDU_LAT. A dependent ID instruction stalls through T+MDU_LAT and proceeds in T+MDU_LAT+1.
- Simultaneous load_hz and mdu_hz: stall until both clear; neither counter is extended.
- Reset (rst_n=0, asynchronous, including mid-stall):
  - State: FSM=RUN, ld_cnt=0, mdu_cnt=0.
  - Outputs forced: pc_write=0, ifid_write=0, haz_mux_con=0, ifid_flush=0, mdu_busy=0.
- After rst_n deasserts, behaviour follows the rules above from the first edge.

## Configuration
- HAZ_STALL_CNT_EN:
  - Defined: adds output stall_count (32 bits). It resets to 0 and increments on every clock edge where pc_write==0 and rst_n==1, saturating at 0xFFFFFFFF.
  - Undefined: port and counter absent; all other behaviour identical.

## Test plan
- LOAD_LAT=1: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> 1 cycle with pc_write=ifid_write=haz_mux_con=0, then all 1.
- LOAD_LAT=3, same hazard, ex_mem_read dropping after 1 cycle -> exactly 3 stall cycles. Repeat with ex_rt=0, or with id_uses_rs=0 -> no stall.
- MDU_LAT=4: ex_mdu_start at T, id_reads_hilo=1 from T+1 -> mdu_busy high T+1..T+4, stall T+1..T+4, release T+5. A restart at T+2 extends busy to T+6.
- LOAD_LAT=3, ex_branch_taken asserted in the 2nd stall cycle -> that cycle ifid_flush=1, pc_write=1, haz_mux_con=0; next cycle no stall (FSM=RUN).
- Assert rst_n=0 mid LD_STALL and mid MDU count -> all outputs 0 immediately. After release with no hazard -> pc_write=1, mdu_busy=0.
- With HAZ_STALL_CNT_EN: a 3-cycle load stall plus a 4-cycle MDU stall -> stall_count=7; reset -> 0.
